// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS-subset control FSM; sequences each instruction
// and issues datapath strobes, with memory-ready wait timeout and illegal-opcode trap.
module multicycle_ctrl #(
    parameter int ALU_OP_W = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          instr_op_i,
    input  logic [5:0]          instr_funct_i,
    input  logic                mem_ready_i,
    input  logic                zero_i,
    output logic                pc_write_o,
    output logic                ir_write_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                iord_o,
    output logic                reg_write_o,
    output logic                reg_dst_o,
    output logic                mem_to_reg_o,
    output logic                jal_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [1:0]          pc_src_o,
    output logic [3:0]          state_o,
    output logic                instr_done_o,
    output logic                error_o
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ERROR    = 4'd15
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_e        state_q, state_d, dec_next;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_wait, timed_out, is_nop, is_jr;
    logic [2:0]    aop;

    assign is_nop    = (instr_op_i == OP_R) && (instr_funct_i == 6'd0);
    assign is_jr     = (instr_op_i == OP_R) && (instr_funct_i == FN_JR);
    assign in_wait   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // ready in the same cycle as the last allowed wait index still wins
    assign timed_out = (TIMEOUT != 0) && in_wait && !mem_ready_i && (cnt_q == CW'(TIMEOUT));

    always_comb begin
        dec_next = S_ERROR;
        case (instr_op_i)
            OP_R:             dec_next = is_nop ? S_FETCH : is_jr ? S_JUMP : S_EXEC_R;
            OP_ADDI, OP_SLTI: dec_next = S_EXEC_I;
            OP_LW, OP_SW:     dec_next = S_MEM_ADDR;
            OP_BEQ:           dec_next = S_BRANCH;
            OP_J, OP_JAL:     dec_next = S_JUMP;
            default:          dec_next = S_ERROR;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = dec_next;
            S_EXEC_R:   state_d = S_WB_ALU;
            S_EXEC_I:   state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_ready_i ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
            S_WB_ALU:   state_d = S_FETCH;
            S_WB_MEM:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_ERROR;
        endcase
        if (timed_out)
            state_d = S_ERROR;
    end

    assign cnt_d = (state_d != state_q) ? '0 :
                   (in_wait && !mem_ready_i) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        jal_o        = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        aop          = 3'b000;
        pc_src_o     = 2'b00;
        instr_done_o = 1'b0;
        error_o      = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    aop         = 3'b011;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_b_o  = 2'b11;
                    aop          = 3'b011;
                    instr_done_o = is_nop;
                end
                S_EXEC_R: alu_src_a_o = 1'b1;
                S_EXEC_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    aop         = (instr_op_i == OP_SLTI) ? 3'b010 : 3'b001;
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    aop         = (instr_op_i == OP_SW) ? 3'b101 : 3'b011;
                end
                S_MEM_RD: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write_o  = 1'b1;
                    iord_o       = 1'b1;
                    instr_done_o = mem_ready_i;
                end
                S_WB_ALU: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = (instr_op_i == OP_R);
                    instr_done_o = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                    instr_done_o = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o  = 1'b1;
                    aop          = 3'b100;
                    pc_src_o     = 2'b01;
                    pc_write_o   = zero_i;
                    instr_done_o = 1'b1;
                end
                S_JUMP: begin
                    pc_write_o   = 1'b1;
                    pc_src_o     = is_jr ? 2'b11 : 2'b10;
                    reg_write_o  = (instr_op_i == OP_JAL);
                    jal_o        = (instr_op_i == OP_JAL);
                    instr_done_o = 1'b1;
                end
                S_ERROR: error_o = 1'b1;
                default: error_o = 1'b0;
            endcase
        end
    end

    assign alu_op_o = ALU_OP_W'(aop);
    assign state_o  = rst_i ? 4'd0 : state_q;
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the MIPS-subset CPU. It replaces the single-cycle opcode decoder with a state machine that sequences each instruction over several cycles and issues every datapath strobe. It waits on a memory ready handshake and detects memory timeouts and illegal opcodes. It sits between the instruction register and a shared-memory datapath (PC, IR, register file, ALU, one memory port).

## Interface
- ALU_OP_W, 3: width of alu_op_o; must be ≥ 3; op codes are zero-extended.
- TIMEOUT, 15: maximum wait-cycle index in a memory state before error; 0 disables the timeout (waits forever).
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- instr_op_i  in  6  opcode, from the IR; stable from DECODE until the next FETCH.
- instr_funct_i  in  6  funct field, from the IR.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- zero_i  in  1  ALU zero flag, used for beq.
- pc_write_o  out  1  PC load enable.
- ir_write_o  out  1  IR load enable.
- mem_read_o / mem_write_o  out  1 each  memory strobes.
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- reg_write_o, reg_dst_o, mem_to_reg_o, jal_o  out  1 each  register-file write controls; jal_o selects $31 and the PC+4 write data.
- alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b_o  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2.
- alu_op_o  out  ALU_OP_W  R=000, addi=001, slti=010, lw=011, beq=100, sw=101, PC-add=011.
- pc_src_o  out  2  PC source: 00 = ALU, 01 = ALUOut (branch), 10 = jump target, 11 = rs (jr).
- state_o  out  4  current state code.
- instr_done_o  out  1  one-cycle pulse on the last cycle of each instruction.
- error_o  out  1  high while in ERROR.

## Operation
- State codes: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JUMP=10, ERROR=15.
- Any output not listed for a state is 0.
- FETCH
  - Drives mem_read=1, iord=0, src_a=0, src_b=01, alu_op=011.
  - When mem_ready_i=1: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: drives src_a=0, src_b=11, alu_op=011 to precompute the branch target. Next state by opcode:
  - op 0 with funct 0 (nop) → FETCH, with instr_done.
  - op 0 with funct 001000 (jr) → JUMP.
  - op 0 with any other funct → EXEC_R.
  - 001000 / 001010 (addi / slti) → EXEC_I.
  - 100011 / 101011 (lw / sw) → MEM_ADDR.
  - 000100 (beq) → BRANCH.
  - 000010 / 000011 (j / jal) → JUMP.
  - Any other opcode → ERROR.
- EXEC_R: src_a=1, src_b=00, alu_op=000 → WB_ALU.
- EXEC_I: src_a=1, src_b=10, alu_op=001 (addi) or 010 (slti) → WB_ALU.
- WB_ALU: reg_write=1, reg_dst=1 for R-type and 0 for I-type → FETCH, with instr_done.
- MEM_ADDR: src_a=1, src_b=10, alu_op=011 (lw) or 101 (sw) → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1; waits for mem_ready_i, then → WB_MEM.
- MEM_WR: mem_write=1, iord=1; waits for mem_ready_i, then → FETCH with instr_done in the ready cycle.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH, with instr_done.
- BRANCH: src_a=1, src_b=00, alu_op=100, pc_src=01, pc_write=zero_i (combinational) → FETCH, with instr_done.
- JUMP: pc_write=1 → FETCH, with instr_done.
  - pc_src=10 for j/jal, 11 for jr.
  - jal additionally drives reg_write=1 and jal_o=1.
- ERROR: every strobe is 0 and error_o=1. The state is sticky until rst_i.
- Wait counter
  - Width is $clog2(TIMEOUT+1), minimum 1 bit.
  - Cleared on every state change; increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready_i=0.
  - If mem_ready_i=0 while the counter equals TIMEOUT (and TIMEOUT≠0), the next state is ERROR.
  - If mem_ready_i=1 arrives in that same cycle, ready wins.

## Timing
- Reset: at the next clock edge with rst_i=1, state=FETCH and counter=0. While rst_i=1, all outputs are forced to 0. This overrides any state, including a reset mid-wait or in ERROR.
- After rst_i falls, the first FETCH read is issued in that same cycle.
- Next state and counter update on the rising edge of clk_i.
- Outputs are decoded combinationally from the state, the opcode, mem_ready_i and zero_i. Strobes therefore only move after a clock edge, apart from mem_ready_i and zero_i effects.
- Cycle counts with zero-wait memory, measured from the first FETCH cycle to the instr_done cycle inclusive:
  - nop: 2
  - j, jal, jr, beq: 3
  - R-type, addi, slti, sw: 4
  - lw: 5
- Each memory wait cycle adds 1. The longest accepted wait is TIMEOUT+1 cycles in a state.
- instr_done_o is exactly one cycle long. The next FETCH starts on the following cycle.

## Test plan
- Reset, then add (op 0, funct 100000) with mem_ready_i tied to 1 → state sequence 0,1,2,7. The state-7 cycle shows reg_write=1, reg_dst=1, instr_done=1.
- lw with 2 wait cycles in MEM_RD → state 5 is held for 3 cycles with mem_read=1, iord=1, then WB_MEM shows mem_to_reg=1 and reg_write=1. Total of 7 cycles.
- beq, once with zero_i=1 and once with zero_i=0 → the BRANCH cycle shows pc_write=1 with pc_src=01, and pc_write=0 respectively. Both take 3 cycles.
- jal then jr → jal's JUMP cycle shows pc_src=10, jal_o=1, reg_write=1. jr's JUMP cycle shows pc_src=11, reg_write=0.
- TIMEOUT=15, mem_ready_i held at 0 in FETCH → ERROR (error_o=1, state_o=15) after 16 wait cycles. A ready arriving on wait index 15 is accepted instead.
- Opcode 111111 → ERROR after DECODE. Asserting rst_i for one cycle returns the block to FETCH with the counter at 0.
